// File: rtl/mole_scoreboard.sv
// mole_scoreboard: whack-a-mole scoring FSM counting switch rising edges against live moles.
module mole_scoreboard #(
  parameter int N_HOLES   = 18,
  parameter int SCORE_W   = 5,
  parameter int MISS_W    = 2,
  parameter int MAX_SCORE = 20,
  parameter int MAX_MISS  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_HOLES-1:0] SW,
  input  logic [N_HOLES-1:0] mole_on,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  miss,
  output logic [SCORE_W-1:0] streak,
  output logic [N_HOLES-1:0] whack,
  output logic               playing,
  output logic               end_game,
  output logic               win
);
  localparam int CW = $clog2(N_HOLES + 1);
  localparam int WW = (SCORE_W > MISS_W ? SCORE_W : MISS_W) + CW + 1;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state_q, state_d;
  logic [N_HOLES-1:0] sw_q, press, hits, misses, whack_q, whack_d;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic [WW-1:0] score_sum, miss_sum, streak_sum;
  logic [SCORE_W-1:0] score_q, score_d, score_nx, streak_q, streak_d, streak_nx;
  logic [MISS_W-1:0] miss_q, miss_d, miss_nx;
  logic win_q, win_d, game_end, score_hit;
  always_comb begin
    press = SW & ~sw_q;
    hits = press & mole_on;
    misses = press & ~mole_on;
    hit_cnt = '0;
    miss_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      hit_cnt = hit_cnt + CW'(hits[i]);
      miss_cnt = miss_cnt + CW'(misses[i]);
    end
  end
  // sums are widened so saturation compares before any wrap can occur
  always_comb begin
    score_sum = WW'(score_q) + WW'(hit_cnt);
    miss_sum = WW'(miss_q) + WW'(miss_cnt);
    streak_sum = WW'(streak_q) + WW'(hit_cnt);
    score_nx = score_sum >= WW'(MAX_SCORE) ? SCORE_W'(MAX_SCORE) : SCORE_W'(score_sum);
    miss_nx = miss_sum >= WW'(MAX_MISS) ? MISS_W'(MAX_MISS) : MISS_W'(miss_sum);
    streak_nx = |miss_cnt ? '0 : streak_sum >= WW'(2 ** SCORE_W - 1) ? '1 : SCORE_W'(streak_sum);
    score_hit = score_nx >= SCORE_W'(MAX_SCORE);
    game_end = score_hit || miss_nx >= MISS_W'(MAX_MISS);
  end
  always_comb begin
    state_d = state_q == PLAY ? (game_end ? OVER : PLAY) : (start ? PLAY : state_q);
  end
  always_comb begin
    score_d = score_q;
    miss_d = miss_q;
    streak_d = streak_q;
    win_d = win_q;
    whack_d = state_q == PLAY ? hits : '0;
    if (state_q == PLAY) begin
      score_d = score_nx;
      miss_d = miss_nx;
      streak_d = streak_nx;
      win_d = game_end & score_hit;
    end else if (start) begin
      score_d = '0;
      miss_d = '0;
      streak_d = '0;
      win_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    sw_q <= SW;
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      miss_q <= '0;
      streak_q <= '0;
      win_q <= 1'b0;
      whack_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      miss_q <= miss_d;
      streak_q <= streak_d;
      win_q <= win_d;
      whack_q <= whack_d;
    end
  end
  always_comb begin
    playing = state_q == PLAY;
    end_game = state_q == OVER;
    score = score_q;
    miss = miss_q;
    streak = streak_q;
    whack = whack_q;
    win = win_q;
  end
endmodule
